// File: rtl/video_timing_pkg.sv
// Shared types and per-standard timing constants for the composite timing generator.
// NTSC_CFG/PAL_CFG are the production values; a parent may override them with a scaled set.
package video_timing_pkg;

  localparam int CW = 11;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t ONE = cnt_t'(1);

  typedef enum logic {STD_NTSC = 1'b0, STD_PAL = 1'b1} std_e;
  typedef enum logic [1:0] {REG_EQ, REG_VSYNC, REG_HSYNC} vregion_e;

  typedef struct packed {
    cnt_t h_total;
    cnt_t h_back_porch;
    cnt_t h_vsync_pulse;
    cnt_t h_eq_pulse;
    cnt_t eq_hl;
    cnt_t field_hl;
    cnt_t v_act_start;
    cnt_t v_act_hl;
  } std_cfg_t;

  localparam std_cfg_t NTSC_CFG = '{h_total: 11'd1588, h_back_porch: 11'd152,
                                    h_vsync_pulse: 11'd678, h_eq_pulse: 11'd58,
                                    eq_hl: 11'd6, field_hl: 11'd525,
                                    v_act_start: 11'd42, v_act_hl: 11'd480};
  localparam std_cfg_t PAL_CFG  = '{h_total: 11'd1600, h_back_porch: 11'd170,
                                    h_vsync_pulse: 11'd682, h_eq_pulse: 11'd59,
                                    eq_hl: 11'd5, field_hl: 11'd625,
                                    v_act_start: 11'd46, v_act_hl: 11'd576};

  localparam cnt_t DEF_H_SYNC        = 11'd118;
  localparam cnt_t DEF_H_ACTIVE      = 11'd1280;
  localparam cnt_t DEF_H_BURST_START = 11'd132;
  localparam cnt_t DEF_H_BURST_END   = 11'd196;

  function automatic std_cfg_t cfg_sel(std_e s, std_cfg_t ntsc, std_cfg_t pal);
    return (s == STD_PAL) ? pal : ntsc;
  endfunction

endpackage

// File: rtl/video_composite_timing_if.sv
// Mode request inputs and registered timing outputs of the composite timing generator.
interface video_composite_timing_if;
  logic pal;
  logic interlace;
  logic sync_n;
  logic color_burst;
  logic burst_vswitch;
  logic active;
  logic next_pixel;
  logic next_line;
  logic next_frame;
  logic vblank_pulse;
  logic current_field;
  logic std_pal;

  modport master (
    input  pal, interlace,
    output sync_n, color_burst, burst_vswitch, active, next_pixel, next_line,
           next_frame, vblank_pulse, current_field, std_pal
  );

  modport slave (
    output pal, interlace,
    input  sync_n, color_burst, burst_vswitch, active, next_pixel, next_line,
           next_frame, vblank_pulse, current_field, std_pal
  );
endinterface

// File: rtl/video_timing_counter.sv
// Pixel and half-line counters, field flag and the shadow mode registers that
// only reload at the frame wrap (or while in reset).
module video_timing_counter
  import video_timing_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pal,
  input  logic interlace,
  input  cnt_t h_total,
  input  cnt_t f_len,
  output std_e std_mode,
  output logic ilace,
  output cnt_t hcnt,
  output cnt_t vcnt,
  output logic field,
  output cnt_t h_half,
  output cnt_t v_last,
  output logic h_last,
  output logic h_half_last
);

  logic frame_wrap;

  assign h_half      = h_total >> 1;
  assign h_last      = (hcnt == h_total - ONE);
  assign h_half_last = h_last || (hcnt == h_half - ONE);
  assign v_last      = {f_len[CW-2:0], 1'b0} - ONE;
  assign frame_wrap  = h_last && (vcnt == v_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt     <= '0;
      vcnt     <= '0;
      field    <= 1'b0;
      std_mode <= std_e'(pal);
      ilace    <= interlace;
    end else begin
      hcnt <= h_last ? '0 : hcnt + ONE;
      if (h_half_last) begin
        if (vcnt == v_last) begin
          vcnt  <= '0;
          field <= 1'b0;
        end else begin
          vcnt <= vcnt + ONE;
          if (vcnt + ONE == f_len) field <= 1'b1;
        end
      end
      // The new mode lands together with the counter wrap, so it governs half-line 0.
      if (frame_wrap) begin
        std_mode <= std_e'(pal);
        ilace    <= interlace;
      end
    end
  end

endmodule

// File: rtl/video_composite_timing.sv
// Dual-standard composite timing generator: counters plus a one-clock registered
// decode of sync, burst, active window and fetch strobes.
module video_composite_timing
  import video_timing_pkg::*;
#(
  parameter std_cfg_t NTSC_SET      = NTSC_CFG,
  parameter std_cfg_t PAL_SET       = PAL_CFG,
  parameter cnt_t     H_SYNC        = DEF_H_SYNC,
  parameter cnt_t     H_ACTIVE      = DEF_H_ACTIVE,
  parameter cnt_t     H_BURST_START = DEF_H_BURST_START,
  parameter cnt_t     H_BURST_END   = DEF_H_BURST_END
) (
  input  logic clk,
  input  logic rst,
  video_composite_timing_if.master vid
);

  std_e     std_mode;
  std_cfg_t cfg;
  logic     ilace, field, h_last, h_half_last;
  cnt_t     hcnt, vcnt, h_half, v_last, f_len;

  assign cfg   = cfg_sel(std_mode, NTSC_SET, PAL_SET);
  assign f_len = cfg.field_hl + {{(CW-1){1'b0}}, ~ilace};

  video_timing_counter u_counter (
    .clk        (clk),
    .rst        (rst),
    .pal        (vid.pal),
    .interlace  (vid.interlace),
    .h_total    (cfg.h_total),
    .f_len      (f_len),
    .std_mode   (std_mode),
    .ilace      (ilace),
    .hcnt       (hcnt),
    .vcnt       (vcnt),
    .field      (field),
    .h_half     (h_half),
    .v_last     (v_last),
    .h_last     (h_last),
    .h_half_last(h_half_last)
  );

  cnt_t     hoff, rel, e2, e3, act_start, act_end, f1_start;
  vregion_e region;
  logic     sync_low, h_act, v_act, burst_d, nl_d, arm_d, vblank_d;

  assign hoff      = (hcnt >= h_half) ? hcnt - h_half : hcnt;
  assign rel       = vcnt - (field ? f_len : '0);
  assign e2        = cfg.eq_hl + cfg.eq_hl;
  assign e3        = e2 + cfg.eq_hl;
  assign act_start = H_SYNC + cfg.h_back_porch;
  assign act_end   = act_start + H_ACTIVE;
  // Field 1 active region is offset by one extra half-line relative to field 0.
  assign f1_start  = f_len + cfg.v_act_start + ONE;

  always_comb begin
    region   = REG_HSYNC;
    sync_low = 1'b0;
    if (rel < cfg.eq_hl)  region = REG_EQ;
    else if (rel < e2)    region = REG_VSYNC;
    else if (rel < e3)    region = REG_EQ;
    case (region)
      REG_EQ:    sync_low = hoff < cfg.h_eq_pulse;
      REG_VSYNC: sync_low = hoff < cfg.h_vsync_pulse;
      default:   sync_low = hcnt < H_SYNC;
    endcase
  end

  assign h_act    = (hcnt >= act_start) && (hcnt < act_end);
  assign v_act    = ((vcnt >= cfg.v_act_start) && (vcnt < cfg.v_act_start + cfg.v_act_hl)) ||
                    ((vcnt >= f1_start) && (vcnt < f1_start + cfg.v_act_hl));
  assign burst_d  = v_act && (hcnt >= H_BURST_START) && (hcnt < H_BURST_END);
  assign nl_d     = (hcnt == act_start - ONE);
  assign arm_d    = h_half_last &&
                    ((vcnt == cfg.v_act_start - ONE) || (vcnt == f1_start - ONE));
  assign vblank_d = h_half_last && ((vcnt == f_len - ONE) || (vcnt == v_last));

  logic sync_n_q, burst_q, vsw_q, active_q, pixel_q, line_q, frame_q, vblank_q;
  logic armed_q, cur_field_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_n_q    <= 1'b1;
      burst_q     <= 1'b0;
      vsw_q       <= 1'b0;
      active_q    <= 1'b0;
      pixel_q     <= 1'b0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      vblank_q    <= 1'b0;
      armed_q     <= 1'b0;
      cur_field_q <= 1'b0;
    end else begin
      sync_n_q <= ~sync_low;
      burst_q  <= burst_d;
      active_q <= h_act && v_act;
      pixel_q  <= h_act;
      line_q   <= nl_d;
      frame_q  <= nl_d && armed_q;
      vblank_q <= vblank_d;
      if (arm_d) begin
        armed_q     <= 1'b1;
        cur_field_q <= field;
      end else if (nl_d) begin
        armed_q <= 1'b0;
      end
      if (std_mode != STD_PAL) vsw_q <= 1'b0;
      else if (h_last)         vsw_q <= ~vsw_q;
    end
  end

  assign vid.sync_n        = sync_n_q;
  assign vid.color_burst   = burst_q;
  assign vid.burst_vswitch = vsw_q;
  assign vid.active        = active_q;
  assign vid.next_pixel    = pixel_q;
  assign vid.next_line     = line_q;
  assign vid.next_frame    = frame_q;
  assign vid.vblank_pulse  = vblank_q;
  assign vid.current_field = cur_field_q;
  assign vid.std_pal       = std_mode;

endmodule

// File: tb/tb_video_composite_timing.sv
// Bench for video_composite_timing on a scaled-down timing set, checked every cycle
// against a frame-position model plus hand-derived per-frame totals.
module tb_video_composite_timing;
  import video_timing_pkg::*;

  localparam std_cfg_t TB_NTSC = '{h_total: 11'd40, h_back_porch: 11'd4,
                                   h_vsync_pulse: 11'd17, h_eq_pulse: 11'd2,
                                   eq_hl: 11'd3, field_hl: 11'd25,
                                   v_act_start: 11'd10, v_act_hl: 11'd12};
  localparam std_cfg_t TB_PAL  = '{h_total: 11'd48, h_back_porch: 11'd6,
                                   h_vsync_pulse: 11'd20, h_eq_pulse: 11'd3,
                                   eq_hl: 11'd2, field_hl: 11'd31,
                                   v_act_start: 11'd8, v_act_hl: 11'd16};
  localparam int HS = 4, HA = 24, BS = 5, BE = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_composite_timing_if vif ();

  video_composite_timing #(
    .NTSC_SET(TB_NTSC), .PAL_SET(TB_PAL),
    .H_SYNC(cnt_t'(HS)), .H_ACTIVE(cnt_t'(HA)),
    .H_BURST_START(cnt_t'(BS)), .H_BURST_END(cnt_t'(BE))
  ) dut (
    .clk(clk),
    .rst(rst),
    .vid(vif)
  );

  int   tests, fails;
  int   p;
  logic m_pal, m_il, armed, cf, vsw;
  int   n_act, n_burst, n_vb, n_nf, n_tog;
  logic prev_vsw;
  logic [1:0] cf_seq;
  logic pl_r, il_r;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_act = 0; n_burst = 0; n_vb = 0; n_nf = 0; n_tog = 0; cf_seq = 2'b00;
    prev_vsw = vif.burst_vswitch;
  endtask

  // One clock: drive inputs, advance the model, compare every output.
  task automatic tick(input logic r, input logic pl, input logic il);
    std_cfg_t c;
    int h, hh, f, e, hc, ho, hl, rel, sa, vas, vah, f1;
    logic low, hact, vact, nl, nf, vb, arm, fld, burst;
    logic [9:0] exp, obs;
    @(negedge clk);
    rst = r; vif.pal = pl; vif.interlace = il;
    if (r) begin
      p = 0; m_pal = pl; m_il = il; armed = 1'b0; cf = 1'b0; vsw = 1'b0;
      exp = {1'b1, 8'b0, pl};
    end else begin
      c   = m_pal ? TB_PAL : TB_NTSC;
      h   = int'(c.h_total);
      hh  = h / 2;
      f   = int'(c.field_hl) + (m_il ? 0 : 1);
      e   = int'(c.eq_hl);
      hc  = p % h;
      ho  = p % hh;
      hl  = p / hh;
      fld = (hl >= f);
      rel = fld ? hl - f : hl;
      if (rel < e || (rel >= 2*e && rel < 3*e)) low = (ho < int'(c.h_eq_pulse));
      else if (rel < 2*e)                       low = (ho < int'(c.h_vsync_pulse));
      else                                      low = (hc < HS);
      sa    = HS + int'(c.h_back_porch);
      vas   = int'(c.v_act_start);
      vah   = int'(c.v_act_hl);
      f1    = f + vas + 1;
      hact  = (hc >= sa) && (hc < sa + HA);
      vact  = (hl >= vas && hl < vas + vah) || (hl >= f1 && hl < f1 + vah);
      burst = vact && (hc >= BS) && (hc < BE);
      nl    = (hc == sa - 1);
      nf    = nl && armed;
      vb    = (ho == hh - 1) && (hl == f - 1 || hl == 2*f - 1);
      arm   = (ho == hh - 1) && (hl == vas - 1 || hl == f1 - 1);
      if (arm) begin armed = 1'b1; cf = fld; end
      else if (nl) armed = 1'b0;
      if (!m_pal) vsw = 1'b0;
      else if (hc == h - 1) vsw = ~vsw;
      p++;
      if (p == h * f) begin p = 0; m_pal = pl; m_il = il; end
      exp = {~low, burst, vsw, vact && hact, hact, nl, nf, vb, cf, m_pal};
    end
    @(posedge clk);
    #1;
    obs = {vif.sync_n, vif.color_burst, vif.burst_vswitch, vif.active, vif.next_pixel,
           vif.next_line, vif.next_frame, vif.vblank_pulse, vif.current_field, vif.std_pal};
    check("outputs", {6'b0, obs}, {6'b0, exp});
    n_act   += int'(obs[6]);
    n_burst += int'(obs[8]);
    n_vb    += int'(obs[2]);
    n_nf    += int'(obs[3]);
    if (obs[7] !== prev_vsw) n_tog++;
    prev_vsw = obs[7];
    if (obs[3]) cf_seq = {cf_seq[0], obs[1]};
  endtask

  initial begin
    tests = 0; fails = 0;
    vif.pal = 1'b0; vif.interlace = 1'b1;
    pl_r = 1'b0; il_r = 1'b1;

    // NTSC interlaced: one full frame, pal request raised mid-frame.
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    check("reset_sync_n", {15'b0, vif.sync_n}, 16'd1);
    clear_counts();
    for (int i = 0; i < 1000; i++) begin
      tick(1'b0, (i >= 500), 1'b1);
      if (i == 0)   check("post_reset_eq", {15'b0, vif.sync_n}, 16'd0);
      if (i == 998) check("std_held_mid_frame", {15'b0, vif.std_pal}, 16'd0);
    end
    check("ntsc_i_active_clks", 16'(n_act), 16'd288);
    check("ntsc_i_burst_clks", 16'(n_burst), 16'd24);
    check("ntsc_i_vblank", 16'(n_vb), 16'd2);
    check("ntsc_i_next_frame", 16'(n_nf), 16'd2);
    check("ntsc_vswitch_quiet", 16'(n_tog), 16'd0);
    check("std_after_wrap", {15'b0, vif.std_pal}, 16'd1);

    // PAL interlaced frame; request NTSC progressive for the next frame.
    clear_counts();
    for (int i = 0; i < 1488; i++) tick(1'b0, 1'b0, 1'b0);
    check("pal_i_active_clks", 16'(n_act), 16'd384);
    check("pal_i_burst_clks", 16'(n_burst), 16'd32);
    check("pal_i_vblank", 16'(n_vb), 16'd2);
    check("pal_i_next_frame", 16'(n_nf), 16'd2);
    check("pal_vswitch_toggles", 16'(n_tog), 16'd31);
    check("std_back_to_ntsc", {15'b0, vif.std_pal}, 16'd0);

    // NTSC progressive frame.
    clear_counts();
    for (int i = 0; i < 1040; i++) tick(1'b0, 1'b0, 1'b0);
    check("ntsc_p_active_clks", 16'(n_act), 16'd288);
    check("ntsc_p_burst_clks", 16'(n_burst), 16'd24);
    check("ntsc_p_vblank", 16'(n_vb), 16'd2);
    check("ntsc_p_next_frame", 16'(n_nf), 16'd2);
    check("ntsc_p_field_order", {14'b0, cf_seq}, 16'd1);

    // Mid-frame reset.
    for (int i = 0; i < 317; i++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    check("midreset_sync_n", {15'b0, vif.sync_n}, 16'd1);
    tick(1'b0, 1'b0, 1'b1);
    check("midreset_eq_low", {15'b0, vif.sync_n}, 16'd0);
    tick(1'b0, 1'b0, 1'b1);
    check("midreset_eq_low2", {15'b0, vif.sync_n}, 16'd0);
    tick(1'b0, 1'b0, 1'b1);
    check("midreset_eq_end", {15'b0, vif.sync_n}, 16'd1);

    // Random mode requests and occasional resets.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 399) == 0) pl_r = ~pl_r;
      if ($urandom_range(0, 399) == 0) il_r = ~il_r;
      tick(($urandom_range(0, 2499) == 0), pl_r, il_r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_composite_timing.md
Name: video_composite_timing

Overview:
- Parametrised dual-standard composite timing generator: NTSC 525/60 or PAL 625/50, interlaced or 263/313-line progressive.
- Selected at run time, with changes applied only at frame boundaries.
- Drives video_modulator (sync_n, color_burst, active) and the line-buffer/palette fetch strobes.
- Adds PAL V-switch (burst phase alternation) and a registered decode stage.

Parameters:
- H_SYNC, 118, hsync pulse length (clocks, both standards)
- NTSC_H_TOTAL, 1588, NTSC line length (clocks); must be even
- PAL_H_TOTAL, 1600, PAL line length (clocks); must be even
- NTSC_H_BACK_PORCH, 152, clocks from end of hsync to first active pixel (NTSC)
- PAL_H_BACK_PORCH, 170, clocks from end of hsync to first active pixel (PAL)
- H_ACTIVE, 1280, active pixels per line
- H_VSYNC_PULSE, 678 / 682, broad pulse length per half-line (NTSC / PAL)
- H_EQ_PULSE, 58 / 59, equalization pulse length (NTSC / PAL)
- H_BURST_START, 132, color burst gate start (clocks)
- H_BURST_END, 196, color burst gate end, exclusive
- NTSC_EQ_HL, 6, half-lines per equalization/vsync group (NTSC)
- PAL_EQ_HL, 5, half-lines per equalization/vsync group (PAL)
- NTSC_FIELD_HL, 525, half-lines per interlaced field (NTSC)
- PAL_FIELD_HL, 625, half-lines per interlaced field (PAL)
- NTSC_V_ACT_START, 42, first active half-line of field 0 (NTSC)
- PAL_V_ACT_START, 46, first active half-line of field 0 (PAL)
- NTSC_V_ACT_HL, 480, active half-lines per field (NTSC)
- PAL_V_ACT_HL, 576, active half-lines per field (PAL)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- pal  in  1  standard request (0 NTSC, 1 PAL)
- interlace  in  1  1: interlaced; 0: progressive (field = FIELD_HL+1 half-lines)
- sync_n  out  1  composite sync, active low
- color_burst  out  1  burst gate
- burst_vswitch  out  1  PAL burst phase; toggles every line, held 0 in NTSC
- active  out  1  pixel visible (h_active && v_active)
- next_pixel  out  1  h_active, independent of vertical state
- next_line  out  1  one-cycle pulse, cycle before first active pixel
- next_frame  out  1  next_line qualified by first active line of a field
- vblank_pulse  out  1  one-cycle pulse at end of each field
- current_field  out  1  field of the current active region (0 even, 1 odd)
- std_pal  out  1  currently applied standard

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Counters:
  - hcnt 0..H_TOTAL-1 wraps.
  - h_half_last is asserted at hcnt==H_TOTAL/2-1 or H_TOTAL-1.
  - vcnt counts half-lines and advances on h_half_last.
  - Field 0 length F = FIELD_HL + !interlace; field 1 length equals F.
  - vcnt wraps to 0 after 2F-1.
  - field register = 1 from vcnt F onward, 0 from wrap.
- Shadow mode:
  - pal and interlace are sampled into std_pal/ilace_r only during rst, or on the cycle hcnt==H_TOTAL-1 && vcnt==2F-1.
  - All H/V limits use the shadow values.
  - Changing the inputs mid-frame has no effect until the wrap.
- Vertical groups, with E=EQ_HL and o = field base (0 or F):
  - o..o+E-1: equalization.
  - o+E..o+2E-1: vsync (broad pulses).
  - o+2E..o+3E-1: equalization.
  - Otherwise: hsync.
- Pulse positions: equalization and broad pulses start at hcnt 0 and H_TOTAL/2; the hsync pulse starts at hcnt 0 only.
- v_active ranges:
  - Field 0: [V_ACT_START, V_ACT_START+V_ACT_HL).
  - Field 1: [F+V_ACT_START+1, F+V_ACT_START+1+V_ACT_HL).
- h_active: hcnt in [H_SYNC+BACK_PORCH, H_SYNC+BACK_PORCH+H_ACTIVE).
- color_burst: v_active && hcnt in [H_BURST_START, H_BURST_END).
- burst_vswitch: toggles at every hcnt==H_TOTAL-1 when std_pal; forced 0 when NTSC.
- Registered decode stage: all outputs are registers. An output at cycle t reflects counter state at t-1, so latency is 1 clock.
- next_frame:
  - An armed flag is set at h_last of the half-line before the first active half-line of each field.
  - It is cleared at the following next_line.
  - current_field is latched at arm time.
- vblank_pulse: h_half_last at vcnt F-1 or 2F-1.
- Reset values:
  - hcnt=0, vcnt=0, field=0.
  - sync_n=1, burst_vswitch=0, current_field=0.
  - All pulses and gates 0.
  - std_pal = pal at reset.
- Reset mid-line: counters restart at 0 the next cycle. The first post-reset output cycle shows the equalization pulse (sync_n=0).
- Simultaneous events: at the frame wrap, the mode update and the counter reset occur in the same cycle. The new mode governs half-line 0.

Decomposition:
- video_timing_pkg holds the per-standard constant sets (H/V limits) and the standard enum (STD_NTSC=0, STD_PAL=1).
- Sub-module video_timing_counter: hcnt/vcnt/field, shadow mode registers, wrap logic.
- The top level holds the decode and output registers.

Test Plan:
- NTSC interlace, after reset -> next frame wrap after 794*1050 = 833,700 clocks; vblank_pulse twice per frame, 416,850 clocks apart.
- NTSC progressive -> frame 794*1052 = 835,288 clocks; next_frame twice per frame; current_field alternates 0/1.
- PAL interlace -> frame 800*1250 = 1,000,000 clocks; at vcnt 5..9 sync_n is low for 682 clocks from hcnt 0 and hcnt 800; burst_vswitch toggles every 1600 clocks.
- Change pal 0->1 at vcnt 300 -> std_pal stays 0 until the cycle after NTSC wrap; next line length 1600.
- Assert rst at hcnt 900, vcnt 700 for 1 cycle -> all outputs at reset values the following cycle; first post-reset output cycle sync_n=0; equalization pulse 58 clocks (NTSC).
- NTSC active window -> active high for exactly 1280 clocks per line on 240 lines per field; color_burst 64 clocks per active line only; never high in the vsync group.
